data_mem_sweep: RTL and testbench
=================================

# data_mem_sweep

Parametrised successor to the CPU's data memory: a single-port synchronous RAM with configurable data width and depth, registered reads with a valid strobe, and a hardware clear engine. The engine zeroes every word by sweeping addresses, replacing the old whole-array reset clear. It runs automatically after reset and on request, and the block reports a busy flag so the core's load/store unit can stall. It sits between the load/store unit and the register file write-back path.

## Interface
- DATA_W, 8, data word width in bits (≥1)
- ADDR_W, 8, address width; depth DEPTH = 2^ADDR_W words
- CLEAR_VAL, 0, DATA_W-bit value written to every word by the clear engine
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset (0 = in reset)
- clear  input  1  clear request, sampled on clk
- writeEn  input  1  write strobe
- readEn  input  1  read strobe
- address  input  ADDR_W  word address for read/write
- dataInput  input  DATA_W  write data
- dataOutput  output  DATA_W  registered read data
- readValid  output  1  dataOutput updated this cycle (1-cycle pulse)
- busy  output  1  clear engine active; accesses rejected
- clearDone  output  1  1-cycle pulse after the last sweep write
- reject  output  1  1-cycle pulse: an access was dropped (busy or clear priority)

## Operation
- States: SWEEP, IDLE. Sweep pointer ptr, ADDR_W bits.
- Reset low (async): state=SWEEP, ptr=0, dataOutput=0, readValid=0, clearDone=0, reject=0, busy=1. Memory contents are undefined while reset is held.
- SWEEP:
  - Each edge writes CLEAR_VAL to mem[ptr] and increments ptr.
  - On the edge that writes ptr=DEPTH-1: state goes to IDLE, ptr wraps to 0, clearDone=1 for the next cycle.
  - writeEn or readEn seen in SWEEP are dropped: no memory change, readValid=0, reject=1 next cycle.
  - clear seen in SWEEP is ignored. It does not restart the sweep and does not assert reject.
- IDLE:
  - clear=1: state goes to SWEEP, ptr=0. Any writeEn/readEn in the same cycle is dropped and reject=1. clear has priority over accesses.
  - writeEn=1: mem[address] ← dataInput.
  - readEn=1: dataOutput ← mem[address], readValid=1 next cycle.
  - readEn and writeEn together at the same address is write-first: dataOutput = dataInput.
- dataOutput holds its last value when no read occurs, including across a sweep. Only reset zeroes it.
- busy is a pure decode of state (state==SWEEP).
- Reset asserted mid-sweep or mid-access aborts the operation. After release the sweep restarts from ptr=0.

## Timing
- Read latency 1: readEn sampled at edge k → dataOutput/readValid valid after edge k, for one cycle.
- Write takes effect at the sampling edge. A read of the same address on the next edge returns the new data.
- Post-reset sweep: busy stays high from reset assertion through exactly DEPTH edges after release. busy=0 and clearDone=1 after edge DEPTH.
- Requested sweep: clear sampled at edge k in IDLE → busy=1 after edge k. Writes occur at edges k+1 … k+DEPTH. busy=0 and clearDone=1 after edge k+DEPTH.
- Total requested-clear latency is DEPTH+1 cycles. An access is accepted again at edge k+DEPTH+1.
- reject, readValid and clearDone are registered. Each is high for exactly one cycle per triggering event.

## Test plan
- Reset and sweep: hold reset low 3 cycles; check busy=1, dataOutput=0 during reset. Release; busy must fall after exactly 256 edges (default params) with one clearDone pulse. Read all 256 addresses → all 0x00, readValid 1 cycle after each readEn.
- Write/readback: write dataInput=i to address i for i=0..255, then read all → i. Simultaneous read+write of 0x5A at address 0x10 → dataOutput=0x5A.
- Requested clear: after the fill, pulse clear with writeEn=1 (address 0x20, data 0xFF) in the same cycle → reject=1, busy high for 257 cycles counted from the clear edge. Address 0x20 reads 0x00, and all addresses read CLEAR_VAL afterwards.
- Access during busy: issue readEn and writeEn (address 0x03, data 0xAA) mid-sweep → reject pulses, readValid stays 0, dataOutput unchanged. After the sweep, address 0x03 reads 0x00.
- Reset mid-sweep: assert reset at sweep cycle 100 → outputs return to reset values immediately. After release, busy high for exactly 256 more edges.
- Parametrisation: DATA_W=16, ADDR_W=4, CLEAR_VAL=0xBEEF → sweep takes 16 cycles, every word reads 0xBEEF, and a 0x1234 write/readback at address 0xF works with ptr wrap to 0.

Source files
------------

// File: rtl/data_mem_sweep.sv
// data_mem_sweep: single-port synchronous RAM with registered reads and a
// sweeping clear engine. The engine runs after reset and on request; busy
// stalls the load/store unit while it runs.
//
//  state | meaning
//  ------+---------------------------------------------------------------
//  SWEEP | clear engine writes CLEAR_VAL to mem[ptr], accesses rejected
//  IDLE  | normal read/write service, clear request starts a new sweep
module data_mem_sweep #(
    parameter int                 DATA_W    = 8,
    parameter int                 ADDR_W    = 8,
    parameter logic [DATA_W-1:0]  CLEAR_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              writeEn,
    input  logic              readEn,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] dataInput,
    output logic [DATA_W-1:0] dataOutput,
    output logic              readValid,
    output logic              busy,
    output logic              clearDone,
    output logic              reject
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SWEEP = 1'b1;

    logic [0:0]        state;
    logic [ADDR_W-1:0] ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              sweeping;
    logic              access;
    logic              accept;
    logic              last_ptr;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    assign sweeping = (state == SWEEP);
    assign access   = writeEn | readEn;
    // clear wins over an access issued in the same IDLE cycle
    assign accept   = !sweeping && !clear;
    assign last_ptr = &ptr;
    assign busy     = sweeping;

    // Single write port shared between the clear engine and the core
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = address;
        mem_wdata = dataInput;
        if (sweeping) begin
            mem_we    = 1'b1;
            mem_addr  = ptr;
            mem_wdata = CLEAR_VAL;
        end else if (accept && writeEn) begin
            mem_we = 1'b1;
        end
    end

    // Storage array has no reset; the sweep initialises it
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    // Sweep sequencing: pointer walks up and wraps to 0 after the last word
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= SWEEP;
            ptr   <= '0;
        end else if (sweeping) begin
            ptr <= ptr + 1'b1;
            if (last_ptr) begin
                state <= IDLE;
            end
        end else if (clear) begin
            state <= SWEEP;
            ptr   <= '0;
        end
    end

    // Registered read data and one-cycle status strobes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dataOutput <= '0;
            readValid  <= 1'b0;
            clearDone  <= 1'b0;
            reject     <= 1'b0;
        end else begin
            readValid <= accept && readEn;
            clearDone <= sweeping && last_ptr;
            reject    <= access && (sweeping || clear);
            if (accept && readEn) begin
                // write-first when both strobes hit the shared address
                dataOutput <= writeEn ? dataInput : mem[address];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_sweep.sv
// Self-checking bench for data_mem_sweep: default-size instance compared
// every cycle against a behavioural model, plus a small 16x16 instance
// checked with directed literal expectations.
module tb_data_mem_sweep;

    localparam int DEPTH = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1;
    logic       clear = 1'b0, we = 1'b0, re = 1'b0;
    logic [7:0] addr = 8'h00, din = 8'h00;
    logic [7:0] dout;
    logic       rv, busy, done, rej;

    logic        s_reset = 1'b1;
    logic        s_clear = 1'b0, s_we = 1'b0, s_re = 1'b0;
    logic [3:0]  s_addr = 4'h0;
    logic [15:0] s_din = 16'h0000;
    logic [15:0] s_dout;
    logic        s_rv, s_busy, s_done, s_rej;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    data_mem_sweep dut (
        .clk(clk), .reset(reset), .clear(clear), .writeEn(we), .readEn(re),
        .address(addr), .dataInput(din), .dataOutput(dout), .readValid(rv),
        .busy(busy), .clearDone(done), .reject(rej)
    );

    data_mem_sweep #(.DATA_W(16), .ADDR_W(4), .CLEAR_VAL(16'hBEEF)) dut_s (
        .clk(clk), .reset(s_reset), .clear(s_clear), .writeEn(s_we), .readEn(s_re),
        .address(s_addr), .dataInput(s_din), .dataOutput(s_dout), .readValid(s_rv),
        .busy(s_busy), .clearDone(s_done), .reject(s_rej)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: remaining sweep edges, a word array, expected strobes
    logic [7:0] m_mem [DEPTH];
    int         m_left;
    logic [7:0] m_dout;
    logic       m_rv, m_rej, m_done;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_left <= DEPTH;
            m_dout <= 8'h00;
            m_rv   <= 1'b0;
            m_rej  <= 1'b0;
            m_done <= 1'b0;
        end else if (m_left > 0) begin
            m_rv   <= 1'b0;
            m_rej  <= we | re;
            m_left <= m_left - 1;
            m_done <= (m_left == 1);
            if (m_left == 1) begin
                for (int i = 0; i < DEPTH; i++) m_mem[i] <= 8'h00;
            end
        end else begin
            m_done <= 1'b0;
            if (clear) begin
                m_left <= DEPTH;
                m_rej  <= we | re;
                m_rv   <= 1'b0;
            end else begin
                m_rej <= 1'b0;
                m_rv  <= re;
                if (we) m_mem[addr] <= din;
                if (re) m_dout <= we ? din : m_mem[addr];
            end
        end
    end

    // Per-cycle comparison of the default instance against the model
    always @(negedge clk) begin
        check("cyc_busy",  32'(busy), 32'(m_left > 0));
        check("cyc_dout",  32'(dout), 32'(m_dout));
        check("cyc_valid", 32'(rv),   32'(m_rv));
        check("cyc_rej",   32'(rej),  32'(m_rej));
        check("cyc_done",  32'(done), 32'(m_done));
        if (done === 1'b1) done_cnt++;
    end

    task automatic drive(input logic c, input logic w, input logic r,
                         input logic [7:0] a, input logic [7:0] d);
        clear = c; we = w; re = r; addr = a; din = d;
        @(negedge clk);
    endtask

    task automatic nop();
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic wait_idle(input string name, input int exp_edges, input int start);
        int n;
        n = start;
        clear = 1'b0; we = 1'b0; re = 1'b0;
        while (busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(n), 32'(exp_edges));
    endtask

    task automatic s_drive(input logic c, input logic w, input logic r,
                           input logic [3:0] a, input logic [15:0] d);
        s_clear = c; s_we = w; s_re = r; s_addr = a; s_din = d;
        @(negedge clk);
    endtask

    task automatic s_wait_idle(input string name, input int exp_edges, input int start);
        int n;
        n = start;
        s_clear = 1'b0; s_we = 1'b0; s_re = 1'b0;
        while (s_busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(n), 32'(exp_edges));
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, got running required finished");
        $fatal(1, "timeout");
    end

    initial begin
        int d0;
        #1 reset = 1'b0; s_reset = 1'b0;

        repeat (3) begin
            @(negedge clk);
            check("rst_busy", 32'(busy), 32'd1);
            check("rst_dout", 32'(dout), 32'h00);
        end

        d0 = done_cnt;
        reset = 1'b1;
        wait_idle("post_reset_edges", 256, 0);
        nop(); nop();
        check("post_reset_done_pulses", 32'(done_cnt - d0), 32'd1);

        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, 1'b0, 1'b1, 8'(i), 8'h00);
            check("rd_zero", 32'(dout), 32'h00);
            check("rd_zero_valid", 32'(rv), 32'd1);
        end
        nop();
        check("valid_drops", 32'(rv), 32'd0);

        for (int i = 0; i < DEPTH; i++) drive(1'b0, 1'b1, 1'b0, 8'(i), 8'(i));
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, 1'b0, 1'b1, 8'(i), 8'h00);
            check("rd_fill", 32'(dout), 32'(i[7:0]));
        end

        drive(1'b0, 1'b1, 1'b1, 8'h10, 8'h5A);
        check("rw_first", 32'(dout), 32'h5A);
        check("rw_first_valid", 32'(rv), 32'd1);

        d0 = done_cnt;
        drive(1'b1, 1'b1, 1'b0, 8'h20, 8'hFF);
        check("clr_reject", 32'(rej), 32'd1);
        check("clr_busy", 32'(busy), 32'd1);
        clear = 1'b0; we = 1'b0;
        repeat (50) nop();
        drive(1'b0, 1'b1, 1'b1, 8'h03, 8'hAA);
        check("busy_reject", 32'(rej), 32'd1);
        check("busy_no_valid", 32'(rv), 32'd0);
        check("busy_dout_hold", 32'(dout), 32'h5A);
        nop();
        check("busy_reject_pulse", 32'(rej), 32'd0);
        // clear edge plus 52 elapsed edges so far; busy falls after edge 257
        wait_idle("clear_busy_edges", 257, 53);
        nop(); nop();
        check("clear_done_pulses", 32'(done_cnt - d0), 32'd1);

        drive(1'b0, 1'b0, 1'b1, 8'h20, 8'h00);
        check("rd_20_cleared", 32'(dout), 32'h00);
        drive(1'b0, 1'b0, 1'b1, 8'h03, 8'h00);
        check("rd_03_cleared", 32'(dout), 32'h00);
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, 1'b0, 1'b1, 8'(i), 8'h00);
            check("rd_after_clear", 32'(dout), 32'h00);
        end

        drive(1'b0, 1'b1, 1'b0, 8'h05, 8'h77);
        drive(1'b0, 1'b0, 1'b1, 8'h05, 8'h00);
        check("rd_77", 32'(dout), 32'h77);

        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        clear = 1'b0;
        repeat (99) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("midrst_busy",  32'(busy), 32'd1);
        check("midrst_dout",  32'(dout), 32'h00);
        check("midrst_valid", 32'(rv),   32'd0);
        check("midrst_rej",   32'(rej),  32'd0);
        check("midrst_done",  32'(done), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        wait_idle("midrst_resweep_edges", 256, 0);
        drive(1'b0, 1'b0, 1'b1, 8'h05, 8'h00);
        check("rd_05_after_resweep", 32'(dout), 32'h00);
        nop();

        s_reset = 1'b1;
        s_wait_idle("small_sweep_edges", 16, 0);
        for (int i = 0; i < 16; i++) begin
            s_drive(1'b0, 1'b0, 1'b1, 4'(i), 16'h0000);
            check("small_rd_beef", 32'(s_dout), 32'hBEEF);
        end
        s_drive(1'b0, 1'b1, 1'b0, 4'hF, 16'h1234);
        s_drive(1'b0, 1'b0, 1'b1, 4'hF, 16'h0000);
        check("small_rd_1234", 32'(s_dout), 32'h1234);
        check("small_rd_valid", 32'(s_rv), 32'd1);
        s_drive(1'b0, 1'b0, 1'b1, 4'h0, 16'h0000);
        check("small_rd_0", 32'(s_dout), 32'hBEEF);
        s_drive(1'b1, 1'b0, 1'b0, 4'h0, 16'h0000);
        s_wait_idle("small_clear_edges", 17, 1);
        s_drive(1'b0, 1'b0, 1'b1, 4'hF, 16'h0000);
        check("small_rd_f_cleared", 32'(s_dout), 32'hBEEF);
        s_drive(1'b0, 1'b1, 1'b1, 4'h0, 16'h1234);
        check("small_rw_0", 32'(s_dout), 32'h1234);
        s_drive(1'b0, 1'b0, 1'b0, 4'h0, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
